// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction memory loader and the fetch-side memory.
// The big-endian byte order lives here so that writer and reader cannot disagree.
package instruction_loader_pkg;

  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // k = 0 selects the most-significant byte, which sits at the lowest address.
  function automatic logic [7:0] byte_sel(input logic [INSTR_W-1:0] word,
                                          input logic [1:0]         k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Session-based program loader: takes 32-bit words over valid/ready and writes
// them big-endian, one byte per cycle, into the byte-wide instruction memory.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam logic [ADDR_W-2:0] MAX_WORDS = (ADDR_W-1)'(DEPTH_BYTES / BYTES_PER_WORD);

  state_t              state, state_nxt;
  logic [1:0]          k;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-2:0]   wcnt;
  logic                full_q;
  logic                fin_pend;
  logic [INSTR_W-1:0]  word_p0;
  logic                idle_like;
  logic                accept;
  logic                last_byte;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = (state == ARMED) && word_valid && !full_q;
  assign last_byte = (state == WRITE) && (k == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A word in flight always finishes its four bytes before finish is honoured.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ARMED;
      ARMED: begin
        if (accept)      state_nxt = WRITE;
        else if (finish) state_nxt = DONE;
      end
      WRITE: if (last_byte) state_nxt = (fin_pend || finish) ? DONE : ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k        <= 2'd0;
      base     <= '0;
      wcnt     <= '0;
      full_q   <= 1'b0;
      fin_pend <= 1'b0;
    end else begin
      if (idle_like && start) begin
        base     <= '0;
        wcnt     <= '0;
        full_q   <= 1'b0;
        fin_pend <= 1'b0;
      end
      if (accept) begin
        k        <= 2'd0;
        fin_pend <= finish;
      end
      if (state == WRITE) begin
        k <= k + 2'd1;
        if (finish) fin_pend <= 1'b1;
        if (k == 2'd3) begin
          base     <= base + ADDR_W'(BYTES_PER_WORD);
          wcnt     <= wcnt + (ADDR_W-1)'(1);
          fin_pend <= 1'b0;
          if (wcnt + (ADDR_W-1)'(1) == MAX_WORDS) full_q <= 1'b1;
        end
      end
    end
  end

  // p0: accepted word held for the four byte-write cycles
  always_ff @(posedge clk) begin
    if (accept) word_p0 <= word_data;
  end

  assign word_ready   = (state == ARMED) && !full_q;
  assign mem_we       = (state == WRITE);
  assign mem_addr     = mem_we ? base + ADDR_W'(k) : '0;
  assign mem_wdata    = mem_we ? byte_sel(word_p0, k) : 8'h00;
  assign busy         = (state == ARMED) || (state == WRITE);
  assign cpu_hold     = busy;
  assign done         = (state == DONE);
  assign full         = full_q;
  assign words_loaded = wcnt;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: table of words with hand-computed bytes, a
// byte-write scoreboard, and hand-written sequences for finish/reset/start corners.
module tb_instruction_loader;

  localparam int DEPTH_BYTES = 128;
  localparam int ADDR_W      = 7;

  logic              clk = 1'b0;
  logic              reset, start, finish, word_valid;
  logic [31:0]       word_data;
  logic              word_ready, mem_we, cpu_hold, busy, done, full;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-2:0] words_loaded;

  always #5 clk = ~clk;

  instruction_loader #(.DEPTH_BYTES(DEPTH_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .full(full),
    .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  e0, e1, e2, e3;
    int          wl;
  } vec_t;

  exp_t              sb[$];
  vec_t              tbl[4];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one clock; every byte write seen is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, nothing expected", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wdata), 32'(e.d));
      end
    end
  endtask

  task automatic push4(input logic [7:0] e0, e1, e2, e3, input int n);
    logic [7:0] bytes [4];
    exp_t e;
    bytes[0] = e0; bytes[1] = e1; bytes[2] = e2; bytes[3] = e3;
    for (int b = 0; b < n; b++) begin
      e.a = exp_addr + ADDR_W'(b);
      e.d = bytes[b];
      sb.push_back(e);
    end
    exp_addr = exp_addr + ADDR_W'(4);
  endtask

  // Present a word, wait (bounded) for ready, queue its bytes, take the accept edge.
  task automatic send_word(input logic [7:0] e0, e1, e2, e3, input logic [31:0] w,
                           input bit keep, output int acc_cyc);
    int n = 0;
    acc_cyc    = -1;
    word_valid = 1'b1;
    word_data  = w;
    while (word_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: word 0x%0h never accepted", w);
      word_valid = 1'b0;
    end else begin
      push4(e0, e1, e2, e3, 4);
      acc_cyc = cyc;
      tick();
      if (!keep) word_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0; word_valid = 1'b0; word_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start    = 1'b1;
    exp_addr = '0;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({word_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, full, words_loaded});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev, nwe;
    logic [31:0] w;

    tbl[0] = '{32'h8B020020, 8'h8B, 8'h02, 8'h00, 8'h20, 1};
    tbl[1] = '{32'hD2800041, 8'hD2, 8'h80, 8'h00, 8'h41, 1};
    tbl[2] = '{32'h91000421, 8'h91, 8'h00, 8'h04, 8'h21, 2};
    tbl[3] = '{32'h00FF7E01, 8'h00, 8'hFF, 8'h7E, 8'h01, 3};

    // Reset state; finish in IDLE ignored
    do_reset();
    chk("reset_outputs", all_outs(), 32'h0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("idle_finish_done", 32'(done), 32'h0);
    chk("idle_finish_busy", 32'(busy), 32'h0);

    // Single word, exact timing
    do_start();
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_hold", 32'(cpu_hold), 32'h1);
    chk("start_ready", 32'(word_ready), 32'h1);
    send_word(tbl[0].e0, tbl[0].e1, tbl[0].e2, tbl[0].e3, tbl[0].w, 1'b0, acc);
    for (int c = 0; c < 4; c++) begin
      chk("t1_we_high", 32'(mem_we), 32'h1);
      chk("t1_ready_low", 32'(word_ready), 32'h0);
      tick();
    end
    chk("t1_we_low", 32'(mem_we), 32'h0);
    chk("t1_ready_back", 32'(word_ready), 32'h1);
    chk("t1_words", 32'(words_loaded), 32'h1);

    // Three back-to-back words then finish
    do_reset();
    do_start();
    prev = -1;
    for (int i = 1; i < 4; i++) begin
      send_word(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].w, 1'b1, acc);
      if (prev >= 0) chk("b2b_spacing", 32'(acc - prev), 32'd5);
      prev = acc;
      repeat (4) tick();
      chk("b2b_words", 32'(words_loaded), 32'(tbl[i].wl));
    end
    word_valid = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("b2b_done", 32'(done), 32'h1);
    chk("b2b_hold", 32'(cpu_hold), 32'h0);
    chk("b2b_busy", 32'(busy), 32'h0);
    chk("b2b_words_final", 32'(words_loaded), 32'd3);

    // Fill memory: 32 words, then an ignored 33rd
    do_reset();
    do_start();
    for (int i = 0; i < DEPTH_BYTES / 4; i++) begin
      w = $urandom;
      send_word(w[31:24], w[23:16], w[15:8], w[7:0], w, 1'b0, acc);
      repeat (4) tick();
    end
    chk("full_flag", 32'(full), 32'h1);
    chk("full_ready", 32'(word_ready), 32'h0);
    word_valid = 1'b1;
    word_data  = 32'hDEADBEEF;
    nwe = 0;
    repeat (8) begin
      tick();
      if (mem_we === 1'b1) nwe++;
    end
    word_valid = 1'b0;
    chk("full_no_write", 32'(nwe), 32'h0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("full_done", 32'(done), 32'h1);
    chk("full_words", 32'(words_loaded), 32'd32);

    // finish in the accepting cycle and again at k=1
    do_reset();
    do_start();
    word_valid = 1'b1;
    word_data  = 32'hA1B2C3D4;
    finish     = 1'b1;
    push4(8'hA1, 8'hB2, 8'hC3, 8'hD4, 4);
    tick();
    word_valid = 1'b0;
    finish     = 1'b0;
    chk("fin_k0_we", 32'(mem_we), 32'h1);
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    chk("fin_k3_we", 32'(mem_we), 32'h1);
    chk("fin_k3_not_done", 32'(done), 32'h0);
    tick();
    chk("fin_after_we", 32'(mem_we), 32'h0);
    chk("fin_done", 32'(done), 32'h1);
    chk("fin_busy", 32'(busy), 32'h0);
    chk("fin_words", 32'(words_loaded), 32'h1);

    // finish only in the accepting cycle; restart from DONE
    do_start();
    chk("restart_words", 32'(words_loaded), 32'h0);
    chk("restart_done", 32'(done), 32'h0);
    word_valid = 1'b1;
    word_data  = 32'h13579BDF;
    finish     = 1'b1;
    push4(8'h13, 8'h57, 8'h9B, 8'hDF, 4);
    tick();
    word_valid = 1'b0;
    finish     = 1'b0;
    repeat (3) tick();
    chk("fin_acc_k3_done", 32'(done), 32'h0);
    tick();
    chk("fin_acc_done", 32'(done), 32'h1);

    // Reset at k=2: three bytes land, then everything clears
    do_reset();
    do_start();
    word_valid = 1'b1;
    word_data  = 32'h0BADF00D;
    push4(8'h0B, 8'hAD, 8'hF0, 8'h0D, 3);
    tick();
    word_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_we", 32'(mem_we), 32'h0);
    chk("rst_mid_outputs", all_outs(), 32'h0);
    do_start();
    send_word(tbl[0].e0, tbl[0].e1, tbl[0].e2, tbl[0].e3, tbl[0].w, 1'b0, acc);
    repeat (4) tick();
    chk("rst_restart_words", 32'(words_loaded), 32'h1);

    // start while ARMED is ignored
    do_reset();
    do_start();
    for (int i = 1; i < 3; i++) begin
      send_word(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].w, 1'b0, acc);
      repeat (4) tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("armed_start_busy", 32'(busy), 32'h1);
    chk("armed_start_words", 32'(words_loaded), 32'd2);
    send_word(tbl[3].e0, tbl[3].e1, tbl[3].e2, tbl[3].e3, tbl[3].w, 1'b0, acc);
    repeat (4) tick();
    chk("armed_start_words3", 32'(words_loaded), 32'd3);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
